// File: rtl/serial_mem_bridge.sv
// Bit-serial bridge from a core request port to an external serial memory:
// 16 address bits out, then 8 data bits in (reads) or out (writes).
module serial_mem_bridge #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        sclk,
    output logic        serial_out,
    input  logic        serial_in,
    input  logic        ready,
    output logic        pc_in_flag,
    output logic        rom_out_flag,
    output logic        ram_in_flag,
    output logic        ram_out_flag
);

    localparam int unsigned StallW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StDataRd, StDataWr, StDone} state_e;

    state_e            state;
    logic [1:0]        op_q;
    logic [23:0]       tx_sreg;
    logic [7:0]        rx_sreg;
    logic [7:0]        div_cnt;
    logic [4:0]        bit_cnt;
    logic [StallW-1:0] stall_cnt;
    logic              first_cyc;
    logic              stall_hit;

    assign stall_hit = (TIMEOUT != 0) && ((32'(stall_cnt) + 32'd1) == TIMEOUT);

    // sclk doubles as the phase bit: 0 = low phase, 1 = high phase of the bit cell.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        err  <= 1'b0;
        if (rst) begin
            state        <= StIdle;
            op_q         <= 2'b00;
            tx_sreg      <= '0;
            rx_sreg      <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            stall_cnt    <= '0;
            first_cyc    <= 1'b0;
            busy         <= 1'b0;
            rdata        <= 8'h00;
            sclk         <= 1'b0;
            serial_out   <= 1'b0;
            pc_in_flag   <= 1'b0;
            rom_out_flag <= 1'b0;
            ram_in_flag  <= 1'b0;
            ram_out_flag <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req && op != 2'b00) begin
                        state        <= StAddr;
                        op_q         <= op;
                        tx_sreg      <= {addr, (op == 2'b11) ? wdata : 8'h00};
                        div_cnt      <= '0;
                        bit_cnt      <= '0;
                        stall_cnt    <= '0;
                        first_cyc    <= 1'b1;
                        busy         <= 1'b1;
                        pc_in_flag   <= 1'b1;
                        rom_out_flag <= (op == 2'b01);
                        ram_out_flag <= (op == 2'b10);
                        ram_in_flag  <= (op == 2'b11);
                    end
                end
                StAddr, StDataRd, StDataWr: begin
                    if (first_cyc) begin
                        // Setup cycle: present bit 0 so it is stable for the whole first cell.
                        first_cyc  <= 1'b0;
                        serial_out <= tx_sreg[23];
                    end else if (!sclk) begin
                        if (ready) begin
                            stall_cnt <= '0;
                            if (div_cnt == DivLast) begin
                                sclk    <= 1'b1;
                                div_cnt <= '0;
                            end else begin
                                div_cnt <= div_cnt + 8'd1;
                            end
                        end else if (stall_hit) begin
                            state        <= StIdle;
                            err          <= 1'b1;
                            busy         <= 1'b0;
                            stall_cnt    <= '0;
                            serial_out   <= 1'b0;
                            pc_in_flag   <= 1'b0;
                            rom_out_flag <= 1'b0;
                            ram_out_flag <= 1'b0;
                            ram_in_flag  <= 1'b0;
                        end else if (stall_cnt != {StallW{1'b1}}) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else if (div_cnt != DivLast) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        // Last high-phase cycle: sample, then open the next bit's low phase.
                        div_cnt    <= '0;
                        sclk       <= 1'b0;
                        bit_cnt    <= bit_cnt + 5'd1;
                        tx_sreg    <= {tx_sreg[22:0], 1'b0};
                        serial_out <= tx_sreg[22];
                        if (state == StDataRd) begin
                            rx_sreg <= {rx_sreg[6:0], serial_in};
                        end
                        if (bit_cnt == 5'd15) begin
                            state      <= (op_q == 2'b11) ? StDataWr : StDataRd;
                            pc_in_flag <= 1'b0;
                        end else if (bit_cnt == 5'd23) begin
                            state        <= StDone;
                            done         <= 1'b1;
                            serial_out   <= 1'b0;
                            rom_out_flag <= 1'b0;
                            ram_out_flag <= 1'b0;
                            ram_in_flag  <= 1'b0;
                            if (state == StDataRd) begin
                                rdata <= {rx_sreg[6:0], serial_in};
                            end
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_mem_bridge.md
SERIAL_MEM_BRIDGE -- requirements
Module: serial_mem_bridge

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per sclk half-period; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 255: maximum consecutive stall cycles before abort; 0 disables the abort.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 req  in  1  transaction request from the core, sampled in IDLE.
REQ-006 op  in  2  01 ROM read, 10 RAM read, 11 RAM write, 00 no-op.
REQ-007 addr  in  16  transaction address, transmitted MSB first.
REQ-008 wdata  in  8  write data, transmitted MSB first.
REQ-009 busy  out  1  high in every state other than IDLE.
REQ-010 done  out  1  one-cycle pulse when a transaction completes.
REQ-011 err  out  1  one-cycle pulse when a transaction is aborted on timeout.
REQ-012 rdata  out  8  read result, held until the next read completes.
REQ-013 sclk  out  1  serial clock to the external memory.
REQ-014 serial_out  out  1  address and write-data bit stream.
REQ-015 serial_in  in  1  read-data bit stream.
REQ-016 ready  in  1  external memory ready; 0 stalls the bit in progress.
REQ-017 pc_in_flag, rom_out_flag, ram_in_flag, ram_out_flag  out  1 each  phase and operation indicators.

Function
REQ-018 States: IDLE, ADDR, DATA_RD, DATA_WR, DONE.
REQ-019 IDLE with req=1 and op!=00: latch op/addr/wdata and go to ADDR on the next cycle; op=00 is ignored.
REQ-020 req is ignored while busy=1; the latched values are not altered.
REQ-021 Bit cell: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles, i.e. 2*CLK_DIV cycles per bit with ready=1.
REQ-022 serial_out changes only on the first cycle of a low phase and stays stable for the entire bit cell.
REQ-023 Low-phase counter advances only while ready=1; sclk is held low while ready=0.
REQ-024 The high phase always completes regardless of ready.
REQ-025 serial_in is sampled in the last clk cycle of the high phase and shifted into rdata LSB-ward, so the first bit lands in bit 7.
REQ-026 ADDR: 16 bits of addr, then go to DATA_RD for op 01/10, or to DATA_WR for op 11.
REQ-027 DATA_RD: 8 bits in; DATA_WR: 8 bits of wdata out; then go to DONE.
REQ-028 DONE: lasts one cycle with done=1 and rdata valid for reads, then go to IDLE; writes leave rdata unchanged.
REQ-029 Latency with ready held at 1: done is high exactly 1+24*2*CLK_DIV cycles after the accept edge (97 at CLK_DIV=2).
REQ-030 Flags: pc_in_flag=1 only in ADDR; rom_out_flag=1 in ADDR/DATA_RD for op 01; ram_out_flag likewise for op 10; ram_in_flag=1 in ADDR/DATA_WR for op 11.
REQ-031 At most one of rom_out_flag, ram_out_flag, ram_in_flag is high at any time.
REQ-032 Stall counter increments each cycle ready=0 during a low phase and clears when ready=1.
REQ-033 If TIMEOUT!=0 and the stall count reaches TIMEOUT: err=1 for one cycle, go to IDLE, done not asserted, rdata unchanged.
REQ-034 A new req may be accepted in the first IDLE cycle after DONE or after abort.
REQ-035 In IDLE: sclk=0, serial_out=0, all flags 0.

Reset
REQ-036 rst=1 at a clock edge, in any state including mid-transaction: next cycle state=IDLE and busy=done=err=sclk=serial_out=0, all flags 0, rdata=8'h00, all counters 0.
REQ-037 A transaction interrupted by reset is discarded and is not resumed.

Verification
REQ-038 ROM read, CLK_DIV=2, addr=16'hA53C, ready=1, serial_in streaming 8'hC3: serial_out carries 1010010100111100; done at cycle 97; rdata=8'hC3.
REQ-039 RAM write, op=11, addr=16'h0001, wdata=8'h5A: 24-bit stream 0x00015A; ram_in_flag high for the whole transaction; rdata unchanged.
REQ-040 RAM read with ready=0 for 10 cycles mid-bit-5, TIMEOUT=255: sclk held low during the stall; done delayed by exactly 10 cycles; data correct.
REQ-041 ready held at 0 for 300 cycles, TIMEOUT=255: err pulses once at stall count 255; state returns to IDLE; no done.
REQ-042 rst asserted during DATA_RD bit 3: all outputs at reset values next cycle; a following ROM read completes normally.
REQ-043 req pulses while busy, plus op=00 in IDLE: no effect, and the in-flight address and data are unchanged.
